// File: rtl/adler32_pkg.sv
// Shared definitions for the adler32 checksum engine and its round-robin
// scheduler: state encodings, data widths and the Adler-32 constants.
package adler32_pkg;
  localparam int SIZE_W = 32;
  localparam int DATA_W = 8;

  // Checksum value of an empty message ({B, A} = {0, 1}).
  localparam logic [31:0] ADLER32_INIT = 32'h0000_0001;
  // Largest prime below 2^16; both running sums are kept modulo this.
  localparam logic [16:0] ADLER_MOD = 17'd65521;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SIZE, ST_START, ST_STREAM, ST_RESULT, ST_DRAIN
  } sched_state_t;

  typedef enum logic [1:0] {
    E_IDLE, E_SIZED, E_DATA, E_DONE
  } eng_state_t;
endpackage

// File: rtl/adler32_sched_if.sv
// Requester-side bus of the adler32 scheduler.
//   master : requesters (drive req/req_size/req_data, see ack/take/result)
//   slave  : scheduler
interface adler32_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  import adler32_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*SIZE_W-1:0] req_size;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        take;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic [31:0]            res_checksum;
  logic                   res_err;
  logic                   busy;

  modport master (
    output req, req_size, req_data,
    input  ack, take, res_valid, res_id, res_checksum, res_err, busy
  );

  modport slave (
    input  req, req_size, req_data,
    output ack, take, res_valid, res_id, res_checksum, res_err, busy
  );
endinterface

// File: rtl/adler32.sv
// Adler-32 checksum engine. Protocol: size_valid latches the byte count,
// data_start (next cycle) clears the sums, then exactly `size` bytes are
// consumed on consecutive cycles. checksum_valid pulses for one cycle after
// the last byte, after which the sums are reinitialised.
//   clock, rst_n   : clock, asynchronous active-low reset
//   size_valid/size: job length (must be non-zero)
//   data_start     : begin streaming
//   data           : one byte per cycle while streaming
//   checksum_valid : one-cycle result strobe
//   checksum       : {B, A}
module adler32
  import adler32_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              size_valid,
  input  logic [SIZE_W-1:0] size,
  input  logic              data_start,
  input  logic [DATA_W-1:0] data,
  output logic              checksum_valid,
  output logic [31:0]       checksum
);
  eng_state_t        state_reg, state_next;
  logic [SIZE_W-1:0] cnt_reg, cnt_next;
  logic [15:0]       a_reg, a_next, b_reg, b_next;
  logic [16:0]       a_sum, b_sum;
  logic [15:0]       a_mod, b_mod;

  // Both sums stay below 2*65521, so one conditional subtract reduces them.
  always_comb begin
    a_sum = {1'b0, a_reg} + {{(17 - DATA_W){1'b0}}, data};
    a_mod = 16'((a_sum >= ADLER_MOD) ? a_sum - ADLER_MOD : a_sum);
    b_sum = {1'b0, b_reg} + {1'b0, a_mod};
    b_mod = 16'((b_sum >= ADLER_MOD) ? b_sum - ADLER_MOD : b_sum);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state_reg)
      E_IDLE: if (size_valid) begin
        cnt_next   = size;
        state_next = E_SIZED;
      end
      E_SIZED: if (data_start) begin
        a_next     = ADLER32_INIT[15:0];
        b_next     = ADLER32_INIT[31:16];
        state_next = E_DATA;
      end
      E_DATA: begin
        a_next   = a_mod;
        b_next   = b_mod;
        cnt_next = cnt_reg - SIZE_W'(1);
        if (cnt_reg == SIZE_W'(1)) state_next = E_DONE;
      end
      E_DONE: begin
        a_next     = ADLER32_INIT[15:0];
        b_next     = ADLER32_INIT[31:16];
        state_next = E_IDLE;
      end
      default: state_next = E_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= E_IDLE;
      cnt_reg   <= '0;
      a_reg     <= ADLER32_INIT[15:0];
      b_reg     <= ADLER32_INIT[31:16];
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
    end
  end

  assign checksum_valid = (state_reg == E_DONE);
  assign checksum       = {b_reg, a_reg};
endmodule

// File: rtl/adler32_rr_pick.sv
// Rotating-priority picker: returns the first requesting index at or after
// rr_ptr, wrapping at NREQ.
//   req    : request vector
//   rr_ptr : index with highest priority this cycle
//   any    : at least one request present
//   id     : winning index (0 when any is low)
module adler32_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  id
);
  logic [IDW:0] idx;

  // Walk from the farthest offset down to offset 0 so the nearest
  // requester to rr_ptr is the last (and therefore winning) assignment.
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (idx >= (IDW + 1)'(NREQ)) idx = idx - (IDW + 1)'(NREQ);
      if (req[idx[IDW-1:0]]) begin
        any = 1'b1;
        id  = idx[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/adler32_sched.sv
// Round-robin scheduler sharing one adler32 engine among NREQ requesters.
// Picks a pending job, drives the engine's size/start/stream sequence,
// muxes the winner's bytes in and returns the id-tagged checksum.
// Zero-length jobs (and, with ADLER32_SCHED_MAXLEN_EN defined, jobs longer
// than MAX_SIZE) are rejected with res_err and checksum 1.
//   clock, rst_n : clock, asynchronous active-low reset (also resets engine)
//   bus          : requester bus (slave side), see adler32_sched_if
module adler32_sched
  import adler32_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int          IDW      = $clog2(NREQ),
  parameter logic [31:0] MAX_SIZE = 32'h0001_0000
) (
  input logic            clock,
  input logic            rst_n,
  adler32_sched_if.slave bus
);
`ifdef ADLER32_SCHED_MAXLEN_EN
  localparam logic [SIZE_W-1:0] SIZE_LIMIT = MAX_SIZE;
`else
  // Every non-zero size is legal; the OR forces an all-ones limit.
  localparam logic [SIZE_W-1:0] SIZE_LIMIT = MAX_SIZE | 32'hFFFF_FFFF;
`endif

  sched_state_t      state_reg, state_next;
  logic [IDW-1:0]    cur_id_reg, cur_id_next;
  logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [SIZE_W-1:0] cnt_reg, cnt_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic              res_valid_reg, res_valid_next;
  logic [IDW-1:0]    res_id_reg, res_id_next;
  logic [31:0]       res_checksum_reg, res_checksum_next;
  logic              res_err_reg, res_err_next;
  logic              busy_reg, busy_next;

  logic              pick_any;
  logic [IDW-1:0]    pick_id;
  logic [SIZE_W-1:0] pick_size;
  logic              size_bad;

  logic [SIZE_W-1:0] size_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  logic              eng_size_valid, eng_data_start, eng_checksum_valid;
  logic [DATA_W-1:0] eng_data;
  logic [31:0]       eng_checksum;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign size_arr[gi]  = bus.req_size[gi*SIZE_W +: SIZE_W];
    assign data_arr[gi]  = bus.req_data[gi*DATA_W +: DATA_W];
    assign bus.take[gi]  = (state_reg == ST_STREAM) && (cur_id_reg == IDW'(gi));
  end

  adler32_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .any    (pick_any),
    .id     (pick_id)
  );

  assign pick_size = size_arr[pick_id];
  assign size_bad  = (pick_size == '0) || (pick_size > SIZE_LIMIT);

  always_comb begin
    state_next        = state_reg;
    cur_id_next       = cur_id_reg;
    rr_ptr_next       = rr_ptr_reg;
    cnt_next          = cnt_reg;
    ack_next          = '0;
    res_valid_next    = 1'b0;
    res_id_next       = res_id_reg;
    res_checksum_next = res_checksum_reg;
    res_err_next      = res_err_reg;
    case (state_reg)
      ST_IDLE: if (pick_any) begin
        cur_id_next = pick_id;
        cnt_next    = pick_size;
        rr_ptr_next = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);
        ack_next    = NREQ'(1) << pick_id;
        if (size_bad) begin
          // Rejected job: acknowledge and report in the same cycle.
          res_valid_next    = 1'b1;
          res_id_next       = pick_id;
          res_checksum_next = ADLER32_INIT;
          res_err_next      = 1'b1;
          state_next        = ST_DRAIN;
        end else begin
          state_next = ST_SIZE;
        end
      end
      ST_SIZE:  state_next = ST_START;
      ST_START: state_next = ST_STREAM;
      ST_STREAM: begin
        cnt_next = cnt_reg - SIZE_W'(1);
        if (cnt_reg == SIZE_W'(1)) state_next = ST_RESULT;
      end
      ST_RESULT: if (eng_checksum_valid) begin
        res_valid_next    = 1'b1;
        res_id_next       = cur_id_reg;
        res_checksum_next = eng_checksum;
        res_err_next      = 1'b0;
        state_next        = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cur_id_reg       <= '0;
      rr_ptr_reg       <= '0;
      cnt_reg          <= '0;
      ack_reg          <= '0;
      res_valid_reg    <= 1'b0;
      res_id_reg       <= '0;
      res_checksum_reg <= '0;
      res_err_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cur_id_reg       <= cur_id_next;
      rr_ptr_reg       <= rr_ptr_next;
      cnt_reg          <= cnt_next;
      ack_reg          <= ack_next;
      res_valid_reg    <= res_valid_next;
      res_id_reg       <= res_id_next;
      res_checksum_reg <= res_checksum_next;
      res_err_reg      <= res_err_next;
      busy_reg         <= busy_next;
    end
  end

  assign eng_size_valid = (state_reg == ST_SIZE);
  assign eng_data_start = (state_reg == ST_START);
  assign eng_data       = data_arr[cur_id_reg];

  adler32 u_engine (
    .clock          (clock),
    .rst_n          (rst_n),
    .size_valid     (eng_size_valid),
    .size           (cnt_reg),
    .data_start     (eng_data_start),
    .data           (eng_data),
    .checksum_valid (eng_checksum_valid),
    .checksum       (eng_checksum)
  );

  assign bus.ack          = ack_reg;
  assign bus.res_valid    = res_valid_reg;
  assign bus.res_id       = res_id_reg;
  assign bus.res_checksum = res_checksum_reg;
  assign bus.res_err      = res_err_reg;
  assign bus.busy         = busy_reg;
endmodule
